// File: rtl/vga_scan_out.sv
// VGA raster generator: 25 MHz pixel strobe derived from a 50 MHz clock, line/frame
// counters, and a one-pixel output pipeline for the colour, sync and blanking signals.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en_r;
  logic [9:0] hc_r;
  logic [9:0] vc_r;
  logic       hs_r;
  logic       vs_r;
  logic       blank_n_r;
  logic [7:0] red_r;
  logic [7:0] green_r;
  logic [7:0] blue_r;
  logic       frame_start_r;

  logic       h_wrap_s;
  logic       v_wrap_s;
  logic [9:0] hc_next_s;
  logic [9:0] vc_next_s;
  logic       vis_s;
  logic       hs_s;
  logic       vs_s;

  // Next counter values and raw (pre-register) timing decodes from the current position.
  always_comb begin
    h_wrap_s = (hc_r == H_LAST);
    v_wrap_s = (vc_r == V_LAST);
    if (h_wrap_s) begin
      hc_next_s = 10'd0;
      if (v_wrap_s) begin
        vc_next_s = 10'd0;
      end else begin
        vc_next_s = vc_r + 10'd1;
      end
    end else begin
      hc_next_s = hc_r + 10'd1;
      vc_next_s = vc_r;
    end
    vis_s = (hc_r < H_VIS) && (vc_r < V_VIS);
    hs_s  = !((hc_r >= HS_START) && (hc_r < HS_END));
    vs_s  = !((vc_r >= VS_START) && (vc_r < VS_END));
  end

  // Pixel strobe: toggles every clock, so pixel work happens on every other edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= ~pix_en_r;
    end
  end

  // Raster counters advance once per pixel; both wrap together at the frame end.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc_r <= 10'd0;
      vc_r <= 10'd0;
    end else if (pix_en_r) begin
      hc_r <= hc_next_s;
      vc_r <= vc_next_s;
    end else begin
      hc_r <= hc_r;
      vc_r <= vc_r;
    end
  end

  // Output pipeline: colour, syncs and blanking share one register stage so they stay aligned.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
      red_r     <= 8'd0;
      green_r   <= 8'd0;
      blue_r    <= 8'd0;
    end else if (pix_en_r) begin
      hs_r      <= hs_s;
      vs_r      <= vs_s;
      blank_n_r <= vis_s;
      red_r     <= vis_s ? Red   : 8'd0;
      green_r   <= vis_s ? Green : 8'd0;
      blue_r    <= vis_s ? Blue  : 8'd0;
    end else begin
      hs_r      <= hs_r;
      vs_r      <= vs_r;
      blank_n_r <= blank_n_r;
      red_r     <= red_r;
      green_r   <= green_r;
      blue_r    <= blue_r;
    end
  end

  // Single-clock pulse on the pixel edge that reloads the origin; clears on the next edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_en_r && h_wrap_s && v_wrap_s;
    end
  end

  assign DrawX       = hc_r;
  assign DrawY       = vc_r;
  assign VGA_CLK     = pix_en_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_n_r;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = red_r;
  assign VGA_G       = green_r;
  assign VGA_B       = blue_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: a full-size instance (A) and a shrunken-timing instance (B) run
// side by side against an arithmetic model derived from the clock count since reset.
module tb_vga_scan_out;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;
  localparam int BVA = 6, BVF = 2, BVS = 2, BVB = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Red = 8'd0, Green = 8'd0, Blue = 8'd0;

  logic [9:0] dx_a, dy_a, dx_b, dy_b;
  logic       clk_a, hs_a, vs_a, bl_a, sy_a, fs_a;
  logic       clk_b, hs_b, vs_b, bl_b, sy_b, fs_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [49:0] act_a, act_b;

  int checks = 0;
  int passed = 0;

  longint      k = 0;
  logic [23:0] smp = 24'h0;

  always #10 Clk = ~Clk;

  vga_scan_out dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(dx_a), .DrawY(dy_a), .VGA_CLK(clk_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sy_a), .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .frame_start(fs_a)
  );

  vga_scan_out #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX(dx_b), .DrawY(dy_b), .VGA_CLK(clk_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sy_b), .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .frame_start(fs_b)
  );

  assign act_a = {dx_a, dy_a, clk_a, hs_a, vs_a, bl_a, sy_a, r_a, g_a, b_a, fs_a};
  assign act_b = {dx_b, dy_b, clk_b, hs_b, vs_b, bl_b, sy_b, r_b, g_b, b_b, fs_b};

  // Clock-edge count since reset release; colour captured on every second edge.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      k = 0;
      smp = 24'h0;
    end else begin
      k = k + 1;
      if (k % 2 == 0) smp = {Red, Green, Blue};
    end
  end

  // Expected outputs after kk clock edges: pixel p = kk/2 is on DrawX/DrawY, pixel p-1 on the DAC.
  function automatic logic [49:0] model(input longint kk, input int ha, input int hf,
                                        input int hs, input int hb, input int va,
                                        input int vf, input int vs, input int vb,
                                        input logic [23:0] c);
    longint ht, vt, p, q;
    longint qh, qv;
    logic [9:0] dx, dy;
    logic vclk, hsn, vsn, vis, fs;
    logic [23:0] rgb;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = kk / 2;
    dx = 10'(p % ht);
    dy = 10'((p / ht) % vt);
    vclk = (kk % 2) == 1;
    hsn = 1'b1; vsn = 1'b1; vis = 1'b0; rgb = 24'h0; fs = 1'b0;
    if (kk >= 2) begin
      q = p - 1;
      qh = q % ht;
      qv = (q / ht) % vt;
      vis = (qh < ha) && (qv < va);
      hsn = !((qh >= ha + hf) && (qh < ha + hf + hs));
      vsn = !((qv >= va + vf) && (qv < va + vf + vs));
      rgb = vis ? c : 24'h0;
      fs = (kk % 2 == 0) && (p % (ht * vt) == 0);
    end
    return {dx, dy, vclk, hsn, vsn, vis, 1'b0, rgb, fs};
  endfunction

  function automatic logic [49:0] exp_a();
    return model(k, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, smp);
  endfunction

  function automatic logic [49:0] exp_b();
    return model(k, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, smp);
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
      @(negedge Clk);
      checks++;
      if (act_a !== exp_a()) $display("FAIL reset_a: got %h want %h", act_a, exp_a());
      else passed++;
      checks++;
      if (act_b !== exp_b()) $display("FAIL reset_b: got %h want %h", act_b, exp_b());
      else passed++;
    end
  endtask

  task automatic test_startup();
    Reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      checks++;
      if (act_a !== exp_a()) $display("FAIL startup_a k=%0d: got %h want %h", k, act_a, exp_a());
      else passed++;
      checks++;
      if (act_b !== exp_b()) $display("FAIL startup_b k=%0d: got %h want %h", k, act_b, exp_b());
      else passed++;
      if (i == 2) begin
        checks++;
        if (dx_a !== 10'd1) $display("FAIL first_advance: DrawX got %0d want 1", dx_a);
        else passed++;
      end
      Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
    end
  endtask

  task automatic test_colour_and_blanking();
    do_reset();
    Green = 8'h55;
    Blue = 8'hAA;
    Red = 8'd0;
    while (k < 1402) begin
      @(negedge Clk);
      Red = 8'((k / 2) % (AHA + AHF + AHS + AHB));
      checks++;
      if (act_a !== exp_a()) $display("FAIL pipe_a k=%0d: got %h want %h", k, act_a, exp_a());
      else passed++;
      checks++;
      if (act_b !== exp_b()) $display("FAIL pipe_b k=%0d: got %h want %h", k, act_b, exp_b());
      else passed++;
      if (k == 12) begin
        checks++;
        if ({r_a, g_a, b_a, bl_a} !== {8'd5, 8'h55, 8'hAA, 1'b1})
          $display("FAIL colour_x5: got %h/%h/%h blank_n=%b want 05/55/aa blank_n=1",
                   r_a, g_a, b_a, bl_a);
        else passed++;
      end
      if (k == 524) begin
        checks++;
        if ({r_b, g_b, b_b, bl_b} !== 25'd0)
          $display("FAIL vblank_b: got %h/%h/%h blank_n=%b want 0", r_b, g_b, b_b, bl_b);
        else passed++;
      end
      if (k == 1402) begin
        checks++;
        if ({r_a, g_a, b_a, bl_a} !== 25'd0)
          $display("FAIL hblank_x700: got %h/%h/%h blank_n=%b want 0", r_a, g_a, b_a, bl_a);
        else passed++;
      end
    end
  endtask

  task automatic test_line_timing();
    int hs_cnt;
    longint hs_first;
    hs_cnt = 0;
    hs_first = -1;
    do_reset();
    for (int i = 1; i <= 1600; i++) begin
      Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
      @(negedge Clk);
      checks++;
      if (act_a !== exp_a()) $display("FAIL line_a k=%0d: got %h want %h", k, act_a, exp_a());
      else passed++;
      if (hs_a === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
    end
    checks++;
    if (hs_cnt != 192) $display("FAIL hs_width: got %0d Clk want 192", hs_cnt);
    else passed++;
    checks++;
    if (hs_first != 1314) $display("FAIL hs_start: got edge %0d want 1314", hs_first);
    else passed++;
    checks++;
    if ({dx_a, dy_a} !== {10'd0, 10'd1})
      $display("FAIL line_period: got x=%0d y=%0d want x=0 y=1", dx_a, dy_a);
    else passed++;
  endtask

  task automatic test_frame_timing();
    int vs_cnt, fs_cnt;
    longint fs_k[2];
    vs_cnt = 0;
    fs_cnt = 0;
    fs_k[0] = -1;
    fs_k[1] = -1;
    do_reset();
    for (int i = 1; i <= 1700; i++) begin
      Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
      @(negedge Clk);
      checks++;
      if (act_b !== exp_b()) $display("FAIL frame_b k=%0d: got %h want %h", k, act_b, exp_b());
      else passed++;
      if (vs_b === 1'b0) vs_cnt++;
      if (fs_b === 1'b1) begin
        if (fs_cnt < 2) fs_k[fs_cnt] = k;
        fs_cnt++;
      end
      if (k == 832) begin
        checks++;
        if ({dx_b, dy_b, fs_b} !== {10'd0, 10'd0, 1'b1})
          $display("FAIL wrap: got x=%0d y=%0d fs=%b want 0 0 1", dx_b, dy_b, fs_b);
        else passed++;
      end
      if (k == 833) begin
        checks++;
        if (fs_b !== 1'b0) $display("FAIL fs_width: got %b want 0", fs_b);
        else passed++;
      end
    end
    checks++;
    if (vs_cnt != 256) $display("FAIL vs_width: got %0d Clk want 256", vs_cnt);
    else passed++;
    checks++;
    if (fs_cnt != 2 || fs_k[0] != 832 || fs_k[1] != 1664)
      $display("FAIL fs_period: got %0d pulses at %0d,%0d want 2 at 832,1664",
               fs_cnt, fs_k[0], fs_k[1]);
    else passed++;
  endtask

  task automatic test_mid_reset();
    longint stop_k[2];
    stop_k[0] = 277;
    stop_k[1] = longint'($urandom_range(300, 1500));
    for (int n = 0; n < 2; n++) begin
      do_reset();
      while (k < stop_k[n]) begin
        Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
        @(negedge Clk);
      end
      #3;
      Reset_n = 1'b0;
      #1;
      checks++;
      if (act_a !== exp_a()) $display("FAIL async_rst_a: got %h want %h", act_a, exp_a());
      else passed++;
      checks++;
      if (act_b !== exp_b()) $display("FAIL async_rst_b: got %h want %h", act_b, exp_b());
      else passed++;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
        Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom);
        @(negedge Clk);
        checks++;
        if (act_a !== exp_a()) $display("FAIL resume_a k=%0d: got %h want %h", k, act_a, exp_a());
        else passed++;
        checks++;
        if (act_b !== exp_b()) $display("FAIL resume_b k=%0d: got %h want %h", k, act_b, exp_b());
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_colour_and_blanking();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 The block SHALL provide these parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
REQ-002 The ports SHALL be, in order:
- Clk, in, 1: 50 MHz system clock.
- Reset_n, in, 1: asynchronous active-low reset.
- Red, in, 8: pixel colour from the colour mapper for the current DrawX/DrawY.
- Green, in, 8: pixel colour from the colour mapper for the current DrawX/DrawY.
- Blue, in, 8: pixel colour from the colour mapper for the current DrawX/DrawY.
- DrawX, out, 10: current horizontal pixel counter.
- DrawY, out, 10: current vertical line counter.
- VGA_CLK, out, 1: 25 MHz pixel clock (Clk/2).
- VGA_HS, out, 1: horizontal sync, active low.
- VGA_VS, out, 1: vertical sync, active low.
- VGA_BLANK_N, out, 1: high while the registered pixel is visible.
- VGA_SYNC_N, out, 1: tied 0.
- VGA_R, out, 8: registered colour output to the DAC.
- VGA_G, out, 8: registered colour output to the DAC.
- VGA_B, out, 8: registered colour output to the DAC.
- frame_start, out, 1: one-Clk pulse at the start of each frame.
REQ-003 One clock (Clk); reset Reset_n is asynchronous and active-low; all flops SHALL reset on the falling edge of Reset_n, independent of Clk.

Function
REQ-004 Internal pix_en SHALL toggle every Clk; VGA_CLK SHALL equal the registered pix_en, giving 25 MHz at 50% duty.
REQ-005 Counters SHALL advance only on Clk edges where pix_en=1; no other state changes except the pix_en toggle.
REQ-006 The horizontal counter hc SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters = 800) and wrap to 0.
REQ-007 The vertical counter vc SHALL increment only when hc wraps; it counts 0..V_TOTAL-1 (525) and wraps to 0.
REQ-008 When hc and vc wrap on the same pixel (hc=799, vc=524), both SHALL return to 0 on that edge.
REQ-009 DrawX SHALL equal hc and DrawY SHALL equal vc, combinationally from the counter registers, for the full 0..799 and 0..524 ranges (not clamped).
REQ-010 Raw hsync SHALL be low for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-011 Raw vsync SHALL be low for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-012 Raw visible SHALL be (hc < H_ACTIVE) AND (vc < V_ACTIVE).
REQ-013 On each pix_en edge, these SHALL be registered together from the current counter values, for a uniform 1-pixel latency relative to DrawX/DrawY:
- Red/Green/Blue, forced to 0 when raw visible=0.
- Raw hsync, raw vsync and raw visible.
REQ-014 The registered values SHALL drive, respectively, VGA_R/G/B, VGA_HS, VGA_VS and VGA_BLANK_N.
REQ-015 Outputs SHALL hold between pix_en edges; no glitch SHALL occur on VGA_HS/VGA_VS (both driven from flops).
REQ-016 frame_start SHALL be 1 for exactly one Clk, on the pix_en edge that loads hc=0, vc=0; it is 0 otherwise.
REQ-017 Red/Green/Blue inputs SHALL be sampled only on pix_en=1 edges; changes at other times have no effect.
REQ-018 All comparisons SHALL be unsigned, 10-bit.

Reset
REQ-019 While Reset_n=0, the following SHALL hold:
- hc=0, vc=0, pix_en=0, VGA_CLK=0.
- VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, frame_start=0.
REQ-020 After Reset_n deassertion, the first pix_en=1 edge SHALL be the second Clk edge; the counters then advance to hc=1.
REQ-021 Reset asserted mid-line or mid-frame SHALL abort immediately; scanning restarts from hc=0, vc=0 with no partial sync pulse carried over.

Verification
REQ-022 Line timing: run one line from reset -> VGA_HS low for exactly 96 pixel periods (192 Clk), starting one pixel after DrawX=656; line period 1600 Clk.
REQ-023 Frame timing: run 2 frames -> VGA_VS low for 2 lines (3200 Clk) starting after DrawY=490, line 0 of the frame; frame_start pulses exactly every 840000 Clk.
REQ-024 Colour pipeline: drive Red=DrawX[7:0], Green=8'h55, Blue=8'hAA -> on the pixel after DrawX=5, DrawY=0, the outputs are VGA_R=5, VGA_G=8'h55, VGA_B=8'hAA, VGA_BLANK_N=1.
REQ-025 Blanking: same stimulus at DrawX=700 or DrawY=500 -> VGA_R/G/B=0 and VGA_BLANK_N=0 one pixel later.
REQ-026 Wrap: step to hc=799, vc=524 -> the next pixel edge gives DrawX=0, DrawY=0 and frame_start=1 for one Clk.
REQ-027 Mid-frame reset: assert Reset_n=0 at DrawX=300, DrawY=200, asynchronously between Clk edges -> all outputs take their reset values without waiting for Clk; after release, scanning resumes from 0,0.
